// File: rtl/cu_pkg.sv
// Shared opcode encodings and the control bundle of the pipelined processor's main control unit.
package cu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b010;
  localparam logic [OP_W-1:0] OP_LDM  = 3'b011;
  localparam logic [OP_W-1:0] OP_LDD  = 3'b100;
  localparam logic [OP_W-1:0] OP_STD  = 3'b101;
  localparam logic [OP_W-1:0] OP_IADD = 3'b110;
  localparam logic [OP_W-1:0] OP_RSVD = 3'b111;

  typedef struct packed {
    logic WB;
    logic Alu;
    logic MR;
    logic MW;
    logic AluOp;
    logic Imm;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: maps a 3-bit opcode to the control bundle.
module cu_decode
  import cu_pkg::*;
(
  input  logic [OP_W-1:0] In,
  output ctrl_t           ctrl
);

  always_comb begin
    // NOTE: defaulting ctrl first keeps this block latch-free and sends
    // reserved or unknown opcodes to the NOP bundle.
    ctrl = CTRL_NOP;
    case (In)
      OP_ADD:  ctrl = '{WB: 1'b1, Alu: 1'b1, MR: 1'b0, MW: 1'b0, AluOp: 1'b0, Imm: 1'b0};
      OP_SUB:  ctrl = '{WB: 1'b1, Alu: 1'b1, MR: 1'b0, MW: 1'b0, AluOp: 1'b1, Imm: 1'b0};
      OP_LDM:  ctrl = '{WB: 1'b1, Alu: 1'b0, MR: 1'b0, MW: 1'b0, AluOp: 1'b0, Imm: 1'b1};
      OP_LDD:  ctrl = '{WB: 1'b1, Alu: 1'b0, MR: 1'b1, MW: 1'b0, AluOp: 1'b0, Imm: 1'b0};
      OP_STD:  ctrl = '{WB: 1'b0, Alu: 1'b0, MR: 1'b0, MW: 1'b1, AluOp: 1'b0, Imm: 1'b0};
      OP_IADD: ctrl = '{WB: 1'b1, Alu: 1'b1, MR: 1'b0, MW: 1'b0, AluOp: 1'b0, Imm: 1'b1};
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main control unit: decodes the opcode and registers the control bundle for
// the decode/execute pipeline register stage.
module control_unit
  import cu_pkg::*;
#(
  parameter int OPW = OP_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] In,
  output logic           WB,
  output logic           Alu,
  output logic           MR,
  output logic           MW,
  output logic           AluOp,
  output logic           Imm
);

  ctrl_t dec;
  ctrl_t ctrl_q;

  cu_decode u_decode (
    .In   (In),
    .ctrl (dec)
  );

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= CTRL_NOP;
    else     ctrl_q <= dec;
  end

  assign WB    = ctrl_q.WB;
  assign Alu   = ctrl_q.Alu;
  assign MR    = ctrl_q.MR;
  assign MW    = ctrl_q.MW;
  assign AluOp = ctrl_q.AluOp;
  assign Imm   = ctrl_q.Imm;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed steps plus random opcodes
// compared against a table-driven reference model with one-cycle latency.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] In;
  logic       WB, Alu, MR, MW, AluOp, Imm;

  int tests = 0;
  int fails = 0;

  // Decode table rows as {WB, Alu, MR, MW, AluOp, Imm}, indexed by opcode.
  logic [5:0] ref_tbl [8] = '{
    6'b000000, 6'b110000, 6'b110010, 6'b100001,
    6'b101000, 6'b000100, 6'b110001, 6'b000000
  };

  control_unit dut (
    .clk   (clk),
    .rst   (rst),
    .In    (In),
    .WB    (WB),
    .Alu   (Alu),
    .MR    (MR),
    .MW    (MW),
    .AluOp (AluOp),
    .Imm   (Imm)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {WB, Alu, MR, MW, AluOp, Imm};
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_invariants(input string tag);
    logic [5:0] o;
    o = outs();
    check({tag, "_mr_mw"},   {5'b0, o[3] & o[2]},  6'b0);
    check({tag, "_mw_wb"},   {5'b0, o[2] & o[5]},  6'b0);
    check({tag, "_aluop"},   {5'b0, o[1] & ~o[4]}, 6'b0);
  endtask

  // Drive inputs on the falling edge, check #1 after the following rising edge.
  task automatic step(input logic r, input logic [2:0] op, input string tag);
    logic [5:0] exp;
    @(negedge clk);
    rst = r;
    In  = op;
    @(posedge clk);
    #1;
    exp = r ? 6'b0 : ref_tbl[op];
    check(tag, outs(), exp);
  endtask

  initial begin
    rst = 1'b1;
    In  = 3'b001;

    // Reset held for two edges with ADD on the input.
    step(1'b1, 3'b001, "reset_1");
    step(1'b1, 3'b001, "reset_2");
    step(1'b0, 3'b001, "first_add");
    check("first_add_exact", outs(), 6'b110000);

    // Full opcode sweep, one per cycle.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'(i), $sformatf("sweep_%0d", i));
      check_invariants($sformatf("sweep_%0d", i));
    end

    // Memory ops back to back.
    step(1'b0, 3'b100, "ldd");
    check("ldd_mr_mw_wb", {3'b0, MR, MW, WB}, 6'b000101);
    step(1'b0, 3'b101, "std");
    check("std_mr_mw_wb", {3'b0, MR, MW, WB}, 6'b000010);

    // Immediate ops.
    step(1'b0, 3'b011, "ldm");
    check("ldm_wb_imm_alu", {3'b0, WB, Imm, Alu}, 6'b000110);
    step(1'b0, 3'b110, "iadd");
    check("iadd_wb_alu_imm_op", {2'b0, WB, Alu, Imm, AluOp}, 6'b001110);

    // Reset mid-stream with SUB held.
    step(1'b1, 3'b010, "mid_reset");
    step(1'b0, 3'b010, "after_reset_sub");
    check("after_reset_sub_exact", outs(), 6'b110010);

    // Mid-cycle input change must not reach the outputs before the next edge.
    #2;
    In = 3'b101;
    #1;
    check("stable_mid_cycle", outs(), 6'b110010);
    @(posedge clk);
    #1;
    check("mid_change_captured", outs(), ref_tbl[5]);

    step(1'b0, 3'b111, "reserved");
    check("reserved_exact", outs(), 6'b000000);

    // Random opcodes with occasional reset pulses.
    for (int n = 0; n < 200; n++) begin
      logic       r;
      logic [2:0] op;
      r  = ($urandom_range(0, 9) == 0);
      op = 3'($urandom_range(0, 7));
      step(r, op, $sformatf("rand_%0d_rst%0d_op%0d", n, r, op));
      check_invariants($sformatf("rand_%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
